// File: rtl/gpio_debounce.sv
// Input conditioning for the GPIO controller: two-flop synchronizer, per-bit
// tick-qualified debounce, and registered rise/fall/change strobes.
module gpio_debounce #(
    parameter int unsigned    NIN       = 16,
    parameter int unsigned    PRESCALE  = 1,
    parameter int unsigned    NSTABLE   = 4,
    parameter logic [NIN-1:0] RESET_VAL = '0
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [NIN-1:0] i_pins,
    output logic [NIN-1:0] o_gpio,
    output logic [NIN-1:0] o_rise,
    output logic [NIN-1:0] o_fall,
    output logic           o_change
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CNT_W = $clog2(NSTABLE + 1);

    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NSTABLE - 1);

    logic [NIN-1:0]            s1_q, s1_d;
    logic [NIN-1:0]            s2_q, s2_d;
    logic [PRE_W-1:0]          pre_q, pre_d;
    logic [NIN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NIN-1:0]            gpio_q, gpio_d;
    logic [NIN-1:0]            rise_q, rise_d;
    logic [NIN-1:0]            fall_q, fall_d;
    logic                      change_q, change_d;

    logic                      tick;
    logic [NIN-1:0]            accept;

    // Synchronizer and prescaler next state
    always_comb begin
        s1_d  = i_pins;
        s2_d  = s1_q;
        tick  = (pre_q == '0);
        pre_d = tick ? PRE_RELOAD : pre_q - PRE_W'(1);
    end

    // Per-bit stability counters; any agreement with o_gpio forgets the glitch
    always_comb begin
        cnt_d  = '0;
        accept = '0;
        for (int i = 0; i < int'(NIN); i++) begin
            if (s2_q[i] != gpio_q[i]) begin
                if (!tick) begin
                    cnt_d[i] = cnt_q[i];
                end else if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Accepted bits always differ from o_gpio, so acceptance is a toggle
    always_comb begin
        gpio_d   = gpio_q ^ accept;
        rise_d   = accept & s2_q;
        fall_d   = accept & ~s2_q;
        change_d = |accept;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q     <= RESET_VAL;
            s2_q     <= RESET_VAL;
            pre_q    <= '0;
            cnt_q    <= '0;
            gpio_q   <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            gpio_q   <= gpio_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign o_gpio   = gpio_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;
    assign o_change = change_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: a vector table for the default instance
// plus hand sequences for reset-abort and prescaler phase latency.
module tb_gpio_debounce;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic [15:0] pins_a, pins_b;
    logic [15:0] gpio_a, rise_a, fall_a;
    logic [15:0] gpio_b, rise_b, fall_b;
    logic        chg_a, chg_b;

    gpio_debounce u_a (
        .i_clk     (clk),
        .i_reset_n (rst_a_n),
        .i_pins    (pins_a),
        .o_gpio    (gpio_a),
        .o_rise    (rise_a),
        .o_fall    (fall_a),
        .o_change  (chg_a)
    );

    gpio_debounce #(
        .NIN       (16),
        .PRESCALE  (4),
        .NSTABLE   (3),
        .RESET_VAL (16'h0001)
    ) u_b (
        .i_clk     (clk),
        .i_reset_n (rst_b_n),
        .i_pins    (pins_b),
        .o_gpio    (gpio_b),
        .o_rise    (rise_b),
        .o_fall    (fall_b),
        .o_change  (chg_b)
    );

    typedef struct {
        logic        rst_n;
        logic [15:0] pins;
        logic [15:0] gpio;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        chg;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add_row(logic r, logic [15:0] p, logic [15:0] g,
                                    logic [15:0] ri, logic [15:0] fa, logic c);
        vec_t v;
        v.rst_n = r; v.pins = p; v.gpio = g; v.rise = ri; v.fall = fa; v.chg = c;
        vecs.push_back(v);
    endfunction

    // Pins move old->new and hold: five quiet edges, update on edge 6, strobe clears on 7
    function automatic void add_settle(logic [15:0] old_v, logic [15:0] new_v);
        for (int k = 1; k <= 5; k++) add_row(1'b1, new_v, old_v, 16'h0, 16'h0, 1'b0);
        add_row(1'b1, new_v, new_v, new_v & ~old_v, old_v & ~new_v, old_v != new_v);
        add_row(1'b1, new_v, new_v, 16'h0, 16'h0, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input logic [15:0] g, input logic [15:0] r,
                           input logic [15:0] f, input logic c);
        n_cmp++;
        if ({gpio_a, rise_a, fall_a, chg_a} !== {g, r, f, c}) begin
            n_bad++;
            $display("FAIL %s: got gpio=%h rise=%h fall=%h chg=%b, want gpio=%h rise=%h fall=%h chg=%b",
                     name, gpio_a, rise_a, fall_a, chg_a, g, r, f, c);
        end
    endtask

    task automatic check_b(input string name, input logic [15:0] g, input logic [15:0] r,
                           input logic [15:0] f, input logic c);
        n_cmp++;
        if ({gpio_b, rise_b, fall_b, chg_b} !== {g, r, f, c}) begin
            n_bad++;
            $display("FAIL %s: got gpio=%h rise=%h fall=%h chg=%b, want gpio=%h rise=%h fall=%h chg=%b",
                     name, gpio_b, rise_b, fall_b, chg_b, g, r, f, c);
        end
    endtask

    int exp_lat[4] = '{13, 12, 11, 14};

    initial begin
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        pins_a  = 16'hFFFF;
        pins_b  = 16'h0001;
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;

        // Reset held with pins high, then release and qualify all bits
        add_row(1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
        add_row(1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
        add_settle(16'h0000, 16'hFFFF);
        // Pin 3 falls, then rises back
        add_settle(16'hFFFF, 16'hFFF7);
        add_settle(16'hFFF7, 16'hFFFF);
        add_settle(16'hFFFF, 16'h0000);
        // Pin 5 high for 3 clocks: rejected
        for (int k = 0; k < 3; k++) add_row(1'b1, 16'h0020, 16'h0, 16'h0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) add_row(1'b1, 16'h0000, 16'h0, 16'h0, 16'h0, 1'b0);
        // Pin 5 high for 4 clocks: accepted, then released four edges later
        for (int k = 0; k < 4; k++) add_row(1'b1, 16'h0020, 16'h0, 16'h0, 16'h0, 1'b0);
        add_row(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add_row(1'b1, 16'h0000, 16'h0020, 16'h0020, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) add_row(1'b1, 16'h0000, 16'h0020, 16'h0, 16'h0, 1'b0);
        add_row(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1'b1);
        add_row(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        // Pin 1 rises while pin 2 falls
        add_settle(16'h0000, 16'h0004);
        add_settle(16'h0004, 16'h0002);

        foreach (vecs[i]) begin
            rst_a_n = vecs[i].rst_n;
            pins_a  = vecs[i].pins;
            step();
            check_a($sformatf("vec%0d", i), vecs[i].gpio, vecs[i].rise, vecs[i].fall, vecs[i].chg);
        end

        // Reset pulsed with pin 8 pending at cnt = 2
        pins_a = 16'h0102;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_a($sformatf("pend_e%0d", e), 16'h0002, 16'h0, 16'h0, 1'b0);
        end
        rst_a_n = 1'b0;
        #1;
        check_a("rst_async", 16'h0000, 16'h0, 16'h0, 1'b0);
        step();
        check_a("rst_held", 16'h0000, 16'h0, 16'h0, 1'b0);
        rst_a_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_a($sformatf("requal_e%0d", e), 16'h0000, 16'h0, 16'h0, 1'b0);
        end
        step();
        check_a("requal_e6", 16'h0102, 16'h0102, 16'h0, 1'b1);
        step();
        check_a("requal_e7", 16'h0102, 16'h0, 16'h0, 1'b0);

        // PRESCALE=4, NSTABLE=3: pin 0 falls at each prescaler phase
        for (int k = 0; k < 4; k++) begin
            int lat;
            rst_b_n = 1'b0;
            pins_b  = 16'h0001;
            step();
            check_b($sformatf("b_rst_ph%0d", k), 16'h0001, 16'h0, 16'h0, 1'b0);
            rst_b_n = 1'b1;
            for (int j = 0; j < k; j++) step();
            pins_b = 16'h0000;
            lat = 0;
            for (int e = 1; e <= 30; e++) begin
                step();
                if (gpio_b[0] == 1'b0) begin
                    lat = e;
                    break;
                end
            end
            n_cmp++;
            if (lat != exp_lat[k]) begin
                n_bad++;
                $display("FAIL b_lat_ph%0d: got edge %0d (0 = timeout), want edge %0d", k, lat, exp_lat[k]);
            end
            check_b($sformatf("b_fall_ph%0d", k), 16'h0000, 16'h0, 16'h0001, 1'b1);
            step();
            check_b($sformatf("b_clr_ph%0d", k), 16'h0000, 16'h0, 16'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
